// File: rtl/qr_pkg.sv
// qr_pkg: shared constants and types for the QR result collector
package qr_pkg;
    localparam int LENGTH = 13;
    localparam int BUS    = 4;
    localparam int N_ROW  = 8;
    localparam int ROW_W  = $clog2(N_ROW);
    localparam int COL_W  = $clog2(BUS);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} qr_col_state_t;
    typedef logic signed [LENGTH-1:0] qr_elem_t;
endpackage

// File: rtl/qr_row_buf.sv
// qr_row_buf: N_ROW x (BUS*LENGTH) register file, one row write port, one element read port
module qr_row_buf
    import qr_pkg::*;
(
    input  logic                    clk,
    input  logic                    we,
    input  logic [ROW_W-1:0]        waddr,
    input  logic [BUS*LENGTH-1:0]   wdata,
    input  logic [ROW_W-1:0]        raddr,
    input  logic [COL_W-1:0]        rcol,
    output qr_elem_t                rdata
);
    logic [BUS*LENGTH-1:0] mem_q [N_ROW];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr][LENGTH*rcol +: LENGTH];
endmodule

// File: rtl/qr_result_collector.sv
// qr_result_collector: captures one N_ROW-beat QR_CORDIC burst, then drains it element by element
module qr_result_collector
    import qr_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [BUS*LENGTH-1:0]   in_data,
    output logic                    elem_valid,
    input  logic                    elem_ready,
    output qr_elem_t                elem_data,
    output logic [ROW_W-1:0]        elem_row,
    output logic [COL_W-1:0]        elem_col,
    output logic                    elem_last,
    output logic                    busy,
    output logic                    overflow
);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROW-1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BUS-1);

    qr_col_state_t    state_q, state_d;
    logic [ROW_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ROW_W-1:0] rd_row_q, rd_row_d;
    logic [COL_W-1:0] rd_col_q, rd_col_d;
    logic             overflow_q, overflow_d;
    logic             wr_en;
    qr_elem_t         rd_data;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rd_row_d   = rd_row_q;
        rd_col_d   = rd_col_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    wr_en      = 1'b1;
                    beat_cnt_d = ROW_W'(1);
                    state_d    = CAPTURE;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    wr_en      = 1'b1;
                    beat_cnt_d = (beat_cnt_q == ROW_LAST) ? '0 : beat_cnt_q + 1'b1;
                    if (beat_cnt_q == ROW_LAST) begin
                        state_d  = DRAIN;
                        rd_row_d = ROW_LAST;
                        rd_col_d = '0;
                    end
                end
            end
            DRAIN: begin
                overflow_d = overflow_q | in_valid;
                if (elem_ready) begin
                    rd_col_d = (rd_col_q == COL_LAST) ? '0 : rd_col_q + 1'b1;
                    rd_row_d = (rd_col_q == COL_LAST) ? rd_row_q - 1'b1 : rd_row_q;
                    state_d  = (rd_col_q == COL_LAST && rd_row_q == '0) ? IDLE : DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            rd_row_q   <= ROW_LAST;
            rd_col_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rd_row_q   <= rd_row_d;
            rd_col_q   <= rd_col_d;
            overflow_q <= overflow_d;
        end
    end

    // Rows fill top-down so the drain (row N_ROW-1 first) replays arrival order
    qr_row_buf u_buf (
        .clk   (clk),
        .we    (wr_en & ~rst),
        .waddr (ROW_LAST - beat_cnt_q),
        .wdata (in_data),
        .raddr (rd_row_q),
        .rcol  (rd_col_q),
        .rdata (rd_data)
    );

    assign elem_valid = (state_q == DRAIN);
    assign elem_data  = elem_valid ? rd_data : '0;
    assign elem_row   = elem_valid ? rd_row_q : '0;
    assign elem_col   = elem_valid ? rd_col_q : '0;
    assign elem_last  = elem_valid && rd_row_q == '0 && rd_col_q == COL_LAST;
    assign busy       = (state_q != IDLE);
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_qr_result_collector.sv
// tb_qr_result_collector: directed table-driven bench for qr_result_collector
module tb_qr_result_collector;
    import qr_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic [BUS*LENGTH-1:0] in_data = '0;
    logic                  elem_valid;
    logic                  elem_ready = 1'b0;
    qr_elem_t              elem_data;
    logic [ROW_W-1:0]      elem_row;
    logic [COL_W-1:0]      elem_col;
    logic                  elem_last;
    logic                  busy;
    logic                  overflow;

    int n_checks = 0;
    int n_fail = 0;
    logic [LENGTH-1:0] mat [N_ROW][BUS];

    typedef struct {
        logic [3:0] pat;
        int         gap;
        int         kind;
        int         exp_cycles;
        logic       exp_ovf;
    } vec_t;
    vec_t vecs[5];

    qr_result_collector dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_data  (elem_data),
        .elem_row   (elem_row),
        .elem_col   (elem_col),
        .elem_last  (elem_last),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build(input int kind);
        for (int r = 0; r < N_ROW; r++)
            for (int c = 0; c < BUS; c++)
                mat[r][c] = (kind == 0) ? LENGTH'(16*r + c) :
                            (kind == 1) ? (((r + c) % 2 != 0) ? 13'h1FFF : 13'h1000) :
                                          LENGTH'(r*37 + c*11 + 5);
    endtask

    function automatic logic [BUS*LENGTH-1:0] pack_row(input int r);
        logic [BUS*LENGTH-1:0] v;
        for (int c = 0; c < BUS; c++) v[LENGTH*c +: LENGTH] = mat[r][c];
        return v;
    endfunction

    task automatic send_burst(input int gap);
        for (int k = 0; k < N_ROW; k++) begin
            in_valid = 1'b1;
            in_data  = pack_row(N_ROW-1-k);
            if (k == N_ROW-1) chk("pre_latency_valid", {31'b0, elem_valid}, 0);
            @(negedge clk);
            if (k == 3 && gap > 0) begin
                in_valid = 1'b0;
                in_data  = '1;
                repeat (gap) @(negedge clk);
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk("latency_valid", {31'b0, elem_valid}, 1);
        chk("latency_busy", {31'b0, busy}, 1);
    endtask

    task automatic drain(input logic [3:0] pat, input int ovf_cyc, input int exp_cycles, input string tag);
        int cnt = 0;
        int cyc = 0;
        while (cnt < N_ROW*BUS && cyc < 400) begin
            elem_ready = pat[cyc%4];
            in_valid   = (cyc == ovf_cyc);
            in_data    = (cyc == ovf_cyc) ? '1 : '0;
            chk({tag, "_valid"}, {31'b0, elem_valid}, 1);
            chk({tag, "_data"}, {19'b0, elem_data}, {19'b0, mat[N_ROW-1-cnt/BUS][cnt%BUS]});
            chk({tag, "_row"}, {29'b0, elem_row}, N_ROW-1-cnt/BUS);
            chk({tag, "_col"}, {30'b0, elem_col}, cnt%BUS);
            chk({tag, "_last"}, {31'b0, elem_last}, {31'b0, cnt == N_ROW*BUS-1});
            if (pat[cyc%4]) cnt++;
            cyc++;
            @(negedge clk);
        end
        in_valid   = 1'b0;
        in_data    = '0;
        elem_ready = 1'b0;
        chk({tag, "_handshakes"}, cnt, N_ROW*BUS);
        chk({tag, "_cycles"}, cyc, exp_cycles);
        chk({tag, "_busy_after"}, {31'b0, busy}, 0);
        chk({tag, "_valid_after"}, {31'b0, elem_valid}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, elem_valid}, 0);
        chk({tag, "_last"}, {31'b0, elem_last}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_overflow"}, {31'b0, overflow}, 0);
        chk({tag, "_data"}, {19'b0, elem_data}, 0);
        chk({tag, "_row"}, {29'b0, elem_row}, 0);
        chk({tag, "_col"}, {30'b0, elem_col}, 0);
    endtask

    initial begin
        vecs[0] = '{4'b1111, 0, 0, 32, 1'b0};
        vecs[1] = '{4'b1001, 0, 0, 64, 1'b0};
        vecs[2] = '{4'b1111, 3, 0, 32, 1'b0};
        vecs[3] = '{4'b1111, 0, 1, 32, 1'b0};
        vecs[4] = '{4'b0110, 0, 1, 63, 1'b0};

        in_valid = 1'b1;
        in_data  = '1;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        check_reset_outputs("reset");

        for (int i = 0; i < 5; i++) begin
            build(vecs[i].kind);
            send_burst(vecs[i].gap);
            drain(vecs[i].pat, -1, vecs[i].exp_cycles, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_overflow", i), {31'b0, overflow}, {31'b0, vecs[i].exp_ovf});
        end

        // Beat coincident with the final handshake must be dropped, not start a capture
        build(0);
        send_burst(0);
        drain(4'b1111, 31, 32, "ovf_last");
        chk("ovf_set", {31'b0, overflow}, 1);
        @(negedge clk);
        chk("ovf_sticky_idle", {31'b0, overflow}, 1);
        chk("ovf_idle_busy", {31'b0, busy}, 0);
        build(0);
        send_burst(0);
        drain(4'b1111, 5, 32, "ovf_mid");
        build(1);
        send_burst(0);
        drain(4'b1111, -1, 32, "ovf_next");
        chk("ovf_still_set", {31'b0, overflow}, 1);

        build(2);
        send_burst(0);
        elem_ready = 1'b1;
        repeat (10) @(negedge clk);
        elem_ready = 1'b0;
        chk("mid_row", {29'b0, elem_row}, 5);
        chk("mid_col", {30'b0, elem_col}, 2);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = '1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        chk("mid_rst_idle", {31'b0, busy}, 0);
        build(0);
        send_burst(0);
        drain(4'b1111, -1, 32, "post_rst");
        chk("post_rst_overflow", {31'b0, overflow}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
